// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - request/response bundle for the RV32I instruction encoder.
interface inst_encoder_if;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [3:0]  io_in_kind;
  logic [2:0]  io_in_funct3;
  logic        io_in_alt;
  logic [4:0]  io_in_rd;
  logic [4:0]  io_in_rs1;
  logic [4:0]  io_in_rs2;
  logic [31:0] io_in_imm;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_inst;
  logic        io_out_illegal;
  logic [15:0] io_count;

  modport slave (
    input  io_in_valid, io_in_kind, io_in_funct3, io_in_alt,
    input  io_in_rd, io_in_rs1, io_in_rs2, io_in_imm, io_out_ready,
    output io_in_ready, io_out_valid, io_out_inst, io_out_illegal, io_count
  );

  modport master (
    output io_in_valid, io_in_kind, io_in_funct3, io_in_alt,
    output io_in_rd, io_in_rs1, io_in_rs2, io_in_imm, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_inst, io_out_illegal, io_count
  );
endinterface

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I instruction encoder with a 2-entry result FIFO and delivery counter.
// Define ENC_CSR_EN to encode SYSTEM requests as Zicsr instructions; otherwise they are illegal.
module inst_encoder (
  input  logic          clock,
  input  logic          reset,
  inst_encoder_if.slave io
);

  logic [31:0] raw_inst;
  logic [31:0] enc_inst;
  logic        enc_illegal;
  logic [6:0]  shift_funct7;
  logic        sext12;
  logic        sext13;
  logic        sext21;

  always_comb begin
    raw_inst     = 32'h0;
    enc_illegal  = 1'b0;
    shift_funct7 = (io.io_in_alt && io.io_in_funct3 == 3'd5) ? 7'h20 : 7'h00;
    sext12 = (&io.io_in_imm[31:11]) || (~|io.io_in_imm[31:11]);
    sext13 = (&io.io_in_imm[31:12]) || (~|io.io_in_imm[31:12]);
    sext21 = (&io.io_in_imm[31:20]) || (~|io.io_in_imm[31:20]);
    case (io.io_in_kind)
      4'd0: begin
        raw_inst = {(io.io_in_alt ? 7'h20 : 7'h00), io.io_in_rs2, io.io_in_rs1,
                    io.io_in_funct3, io.io_in_rd, 7'h33};
        enc_illegal = io.io_in_alt && io.io_in_funct3 != 3'd0 && io.io_in_funct3 != 3'd5;
      end
      4'd1: begin
        if (io.io_in_funct3 == 3'd1 || io.io_in_funct3 == 3'd5) begin
          raw_inst = {shift_funct7, io.io_in_imm[4:0], io.io_in_rs1,
                      io.io_in_funct3, io.io_in_rd, 7'h13};
          enc_illegal = |io.io_in_imm[31:5];
        end else begin
          raw_inst = {io.io_in_imm[11:0], io.io_in_rs1, io.io_in_funct3, io.io_in_rd, 7'h13};
          enc_illegal = !sext12;
        end
      end
      4'd2: begin
        raw_inst = {io.io_in_imm[11:0], io.io_in_rs1, io.io_in_funct3, io.io_in_rd, 7'h03};
        enc_illegal = !sext12 || io.io_in_funct3 == 3'd3 ||
                      io.io_in_funct3 == 3'd6 || io.io_in_funct3 == 3'd7;
      end
      4'd3: begin
        raw_inst = {io.io_in_imm[11:5], io.io_in_rs2, io.io_in_rs1, io.io_in_funct3,
                    io.io_in_imm[4:0], 7'h23};
        enc_illegal = !sext12 || io.io_in_funct3 > 3'd2;
      end
      4'd4: begin
        raw_inst = {io.io_in_imm[12], io.io_in_imm[10:5], io.io_in_rs2, io.io_in_rs1,
                    io.io_in_funct3, io.io_in_imm[4:1], io.io_in_imm[11], 7'h63};
        enc_illegal = io.io_in_imm[0] || !sext13 ||
                      io.io_in_funct3 == 3'd2 || io.io_in_funct3 == 3'd3;
      end
      4'd5: begin
        raw_inst = {io.io_in_imm[20], io.io_in_imm[10:1], io.io_in_imm[11],
                    io.io_in_imm[19:12], io.io_in_rd, 7'h6f};
        enc_illegal = io.io_in_imm[0] || !sext21;
      end
      4'd6: begin
        raw_inst = {io.io_in_imm[11:0], io.io_in_rs1, 3'd0, io.io_in_rd, 7'h67};
        enc_illegal = !sext12;
      end
      4'd7: raw_inst = {io.io_in_imm[31:12], io.io_in_rd, 7'h37};
      4'd8: raw_inst = {io.io_in_imm[31:12], io.io_in_rd, 7'h17};
`ifdef ENC_CSR_EN
      4'd9: begin
        // rs1 field carries the 5-bit uimm for the immediate CSR forms unchanged.
        raw_inst = {io.io_in_imm[11:0], io.io_in_rs1, io.io_in_funct3, io.io_in_rd, 7'h73};
        enc_illegal = io.io_in_funct3 == 3'd0 || io.io_in_funct3 == 3'd4;
      end
`else
      4'd9: enc_illegal = 1'b1;
`endif
      default: enc_illegal = 1'b1;
    endcase
    enc_inst = enc_illegal ? 32'h0 : raw_inst;
  end

  // Result FIFO: each entry is {illegal, inst}.
  logic [32:0] mem_q [2];
  logic [32:0] mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  occ_q, occ_d;
  logic [15:0] count_q, count_d;
  logic        push;
  logic        pop;

  assign io.io_in_ready    = occ_q != 2'd2;
  assign io.io_out_valid   = occ_q != 2'd0;
  assign io.io_out_inst    = io.io_out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign io.io_out_illegal = io.io_out_valid ? mem_q[rd_ptr_q][32] : 1'b0;
  assign io.io_count       = count_q;

  assign push = io.io_in_valid && io.io_in_ready;
  assign pop  = io.io_out_valid && io.io_out_ready;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {enc_illegal, enc_inst};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      count_d  = count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= 33'h0;
      mem_q[1] <= 33'h0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      count_q  <= 16'h0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed scoreboard bench for inst_encoder.
module tb_inst_encoder;

  logic clock;
  logic reset;
  inst_encoder_if io ();

  inst_encoder dut (
    .clock (clock),
    .reset (reset),
    .io    (io.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_assert;
  int          n_fail;
  logic [32:0] sb [$];
  logic [32:0] cur_exp;
  logic [15:0] exp_cnt;
  int          delivered;
  bit          accepted;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [32:0] e;
    if (io.io_out_valid && io.io_out_ready) begin
      chk("sb_nonempty", 33'(sb.size() != 0), 33'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", {io.io_out_illegal, io.io_out_inst}, e);
      end
      exp_cnt++;
      delivered++;
    end
    accepted = io.io_in_valid && io.io_in_ready;
    if (accepted) sb.push_back(cur_exp);
    @(posedge clock);
    #1;
    chk("count", 33'(io.io_count), 33'(exp_cnt));
  endtask

  task automatic set_req(input logic [3:0] kind, input logic [2:0] f3, input logic alt,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic ill, input logic [31:0] inst);
    io.io_in_kind   = kind;
    io.io_in_funct3 = f3;
    io.io_in_alt    = alt;
    io.io_in_rd     = rd;
    io.io_in_rs1    = rs1;
    io.io_in_rs2    = rs2;
    io.io_in_imm    = imm;
    io.io_in_valid  = 1'b1;
    cur_exp         = {ill, inst};
  endtask

  task automatic send(input string tag, input logic [3:0] kind, input logic [2:0] f3,
                      input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic ill, input logic [31:0] inst);
    int n;
    set_req(kind, f3, alt, rd, rs1, rs2, imm, ill, inst);
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 20) begin
      tick();
      n++;
    end
    io.io_in_valid = 1'b0;
    chk({tag, "_accept"}, 33'(accepted), 33'd1);
    chk({tag, "_valid"}, 33'(io.io_out_valid), 33'd1);
    if (sb.size() == 1) chk(tag, {io.io_out_illegal, io.io_out_inst}, {ill, inst});
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic do_reset();
    logic keep_ready;
    keep_ready = io.io_out_ready;
    io.io_in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 33'(io.io_out_valid), 33'd0);
    chk("rst_inst", {io.io_out_illegal, io.io_out_inst}, 33'd0);
    chk("rst_count", 33'(io.io_count), 33'd0);
    chk("rst_in_ready", 33'(io.io_in_ready), 33'd1);
    io.io_in_valid  = 1'b1;
    io.io_out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_no_push", 33'(io.io_out_valid), 33'd0);
    chk("rst_no_count", 33'(io.io_count), 33'd0);
    io.io_in_valid  = 1'b0;
    io.io_out_ready = keep_ready;
    #2;
    reset = 1'b1;
    sb.delete();
    exp_cnt   = 16'h0;
    delivered = 0;
    @(posedge clock);
    #1;
  endtask

  logic [32:0] csr_exp;
  int          guard;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_cnt  = 16'h0;
    delivered = 0;
    accepted = 1'b0;
    cur_exp  = 33'h0;
    reset    = 1'b0;
    io.io_in_valid  = 1'b0;
    io.io_in_kind   = 4'd0;
    io.io_in_funct3 = 3'd0;
    io.io_in_alt    = 1'b0;
    io.io_in_rd     = 5'd0;
    io.io_in_rs1    = 5'd0;
    io.io_in_rs2    = 5'd0;
    io.io_in_imm    = 32'h0;
    io.io_out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("init_out_valid", 33'(io.io_out_valid), 33'd0);
    chk("init_inst", {io.io_out_illegal, io.io_out_inst}, 33'd0);
    chk("init_count", 33'(io.io_count), 33'd0);
    chk("init_in_ready", 33'(io.io_in_ready), 33'd1);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;

    io.io_out_ready = 1'b1;
`ifdef ENC_CSR_EN
    csr_exp = {1'b0, 32'h300110F3};
`else
    csr_exp = {1'b1, 32'h0};
`endif
    send("r_add",     4'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0,        1'b0, 32'h003100B3);
    send("r_sub",     4'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0,        1'b0, 32'h403100B3);
    send("r_bad_alt", 4'd0, 3'd1, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0,        1'b1, 32'h0);
    send("addi_m1",   4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00293);
    send("addi_800",  4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h00000800, 1'b1, 32'h0);
    send("srai",      4'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,        1'b0, 32'h40315093);
    send("slli_alt",  4'd1, 3'd1, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,        1'b0, 32'h00311093);
    send("slli_big",  4'd1, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0, 32'd32,       1'b1, 32'h0);
    send("beq_8",     4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,        1'b0, 32'h00208463);
    send("beq_7",     4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7,        1'b1, 32'h0);
    send("b_f3_2",    4'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,        1'b1, 32'h0);
    send("sw_m4",     4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFC, 1'b0, 32'hFE312E23);
    send("ld_f3_3",   4'd2, 3'd3, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0,        1'b1, 32'h0);
    send("jal_8",     4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,        1'b0, 32'h008000EF);
    send("jal_far",   4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00100000, 1'b1, 32'h0);
    send("jalr",      4'd6, 3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4,        1'b0, 32'h004100E7);
    send("lui",       4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h123452B7);
    send("auipc",     4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF000, 1'b0, 32'hFFFFF097);
    send("csrrw",     4'd9, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h300, csr_exp[32], csr_exp[31:0]);
    send("csr_f3_0",  4'd9, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h300,      1'b1, 32'h0);
    send("undef",     4'd12, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0,       1'b1, 32'h0);
    drain(3);
    chk("sb_drained", 33'(sb.size()), 33'd0);

    // Backpressure: two fill the FIFO, the third waits for space.
    do_reset();
    io.io_out_ready = 1'b0;
    send("bp_a", 4'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h003100B3);
    send("bp_b", 4'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h403100B3);
    chk("bp_full_ready", 33'(io.io_in_ready), 33'd0);
    set_req(4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h123452B7);
    tick();
    tick();
    chk("bp_c_held", 33'(accepted), 33'd0);
    chk("bp_head_stable", {io.io_out_illegal, io.io_out_inst}, {1'b0, 32'h003100B3});
    io.io_out_ready = 1'b1;
    chk("bp_full_with_pop", 33'(io.io_in_ready), 33'd0);
    accepted = 1'b0;
    guard = 0;
    while (!accepted && guard < 20) begin
      tick();
      guard++;
    end
    io.io_in_valid = 1'b0;
    chk("bp_c_accept", 33'(accepted), 33'd1);
    drain(3);
    chk("bp_count3", 33'(io.io_count), 33'd3);
    chk("bp_sb_empty", 33'(sb.size()), 33'd0);

    // Reset with a full FIFO and a nonzero count.
    io.io_out_ready = 1'b0;
    send("full_a", 4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00293);
    send("full_b", 4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h800,      1'b1, 32'h0);
    chk("full_ready", 33'(io.io_in_ready), 33'd0);
    do_reset();

    // Counter wrap: 65535 deliveries, fill, then the 65536th delivery wraps.
    io.io_out_ready = 1'b1;
    set_req(4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h00000037);
    guard = 0;
    while (delivered < 65535 && guard < 70000) begin
      tick();
      guard++;
    end
    chk("bulk_delivered", 33'(delivered), 33'd65535);
    chk("count_ffff", 33'(io.io_count), 33'h0FFFF);
    io.io_out_ready = 1'b0;
    tick();
    io.io_in_valid = 1'b0;
    chk("wrap_full", 33'(io.io_in_ready), 33'd0);
    io.io_out_ready = 1'b1;
    tick();
    chk("count_wrap", 33'(io.io_count), 33'd0);
    drain(3);
    chk("wrap_sb_empty", 33'(sb.size()), 33'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
